ren_simd_arb: RTL and testbench
===============================

Name: ren_simd_arb

Overview:
- Round-robin arbiter and sequencer that shares one 4-lane FP_SIMD unit between several setup-stage requesters, such as triangle setup and attribute/tile helpers.
- Latches the winner's operands and opcode, and holds SIMD enable until the result is valid.
- Returns the captured result with a one-cycle done pulse to the owning requester.
- Includes a watchdog that aborts a hung operation.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- DW, 22, FP word width (sign, 5-bit exponent, 16-bit fraction format).
- LANES, 4, SIMD lanes.
- OPW, 3, opcode width.
- TIMEOUT, 255, max cycles waiting for i_simd_valid before abort (≥1).

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous reset, ACTIVE-HIGH despite the name (matches codebase usage).
- i_req  in  N_REQ  per-requester request level.
- i_in1  in  N_REQ*LANES*DW  operand A; slice r is [r*LANES*DW +: LANES*DW].
- i_in2  in  N_REQ*LANES*DW  operand B, same slicing.
- i_opcode  in  N_REQ*OPW  opcode per requester.
- o_grant  out  N_REQ  one-hot, 1-cycle pulse when operands are latched.
- o_done  out  N_REQ  one-hot, 1-cycle pulse when o_result is valid for that requester.
- o_err  out  1  1-cycle pulse with o_done on watchdog abort.
- o_result  out  LANES*DW  captured SIMD output.
- o_idle  out  1  high in S_IDLE.
- o_simd_en  out  1  SIMD enable.
- o_simd_in1  out  LANES*DW  latched operand A.
- o_simd_in2  out  LANES*DW  latched operand B.
- o_simd_opcode  out  OPW  latched opcode.
- i_simd_out  in  LANES*DW  SIMD result.
- i_simd_valid  in  1  SIMD result valid.
- i_simd_busy  in  1  SIMD busy.

Behaviour:
- Reset (rstn=1 at posedge):
  - state S_IDLE; rr pointer 0; owner 0; watchdog 0.
  - All outputs 0 except o_idle=1.
  - Reset mid-operation drops o_simd_en the next cycle. No done/err pulse is emitted.
- FSM S_IDLE -> S_ISSUE -> S_DONE -> S_IDLE.
- S_IDLE:
  - Arbitrate when |i_req and !i_simd_busy.
  - Winner is the first requester with i_req set, searching from the rr pointer upward with wrap.
  - At the edge: latch winner's in1/in2/opcode into o_simd_*, set owner, clear watchdog, go to S_ISSUE.
  - If i_simd_busy=1, remain in S_IDLE; no grant.
- S_ISSUE:
  - o_simd_en=1 for every cycle of the state. o_grant[owner]=1 in the first S_ISSUE cycle only.
  - Operands and opcode stay stable regardless of i_in*/i_req changes.
  - i_simd_valid=1: capture i_simd_out into o_result, go to S_DONE.
  - Otherwise increment watchdog. When watchdog==TIMEOUT and valid is still 0: o_result=0, set err flag, go to S_DONE.
  - Valid in the same cycle the watchdog reaches TIMEOUT counts as success; valid wins.
- S_DONE:
  - o_simd_en=0. o_done[owner]=1; o_err=err flag.
  - rr pointer <= (owner+1) mod N_REQ. Clear err flag. Go to S_IDLE.
- o_result holds its value until the next capture. It is valid with o_done and afterward until the next S_DONE.
- Requester handshake:
  - Hold i_req and operands until o_grant.
  - Deassert i_req on the edge that samples o_done (or earlier, after o_grant) unless issuing a new op.
  - i_req high in S_IDLE is always a new request.
  - Dropping i_req after grant does not cancel the op; the done pulse is still issued.
- Latency: request seen in S_IDLE at cycle 0 -> grant at cycle 1 -> valid at cycle 1+L -> done at cycle 2+L, where L ≥ 0 is the number of S_ISSUE cycles before i_simd_valid.
  - Back-to-back throughput is one op per L+3 cycles.
- Fairness: a continuously requesting requester cannot win twice in a row while another requests.
- No arithmetic on data. Watchdog width is $clog2(TIMEOUT+1).

Decomposition:
- Shared package/header: state encodings (S_IDLE=0, S_ISSUE=1, S_DONE=2), SIMD opcodes (ADD=0, SUB=1, MUL=2), lane width and lane count macros.
- One sub-module, ren_rr_pick: combinational round-robin priority picker, with inputs req[N_REQ] and ptr and outputs one-hot gnt plus an index. Reused by future binner arbiters.

Test Plan:
1. Single op: N_REQ=2, req0=1, opcode=2, SIMD model L=3, result 0x..ABC -> grant0 at c1, en high c1..c4, done0 at c5, o_result=0x..ABC, err=0.
2. Contention: req0=req1=1 from reset -> order 0,1,0,1. Done pulses alternate; no requester is granted twice consecutively.
3. Busy gating: i_simd_busy=1 for 5 cycles with req1=1 -> no grant and en=0 during those cycles; grant1 the cycle after busy drops.
4. Watchdog: TIMEOUT=4, SIMD never valid -> en high 5 cycles, then done+err pulse, o_result=0. The next request is serviced normally.
5. Reset mid-op: assert rstn during S_ISSUE cycle 2 -> next cycle en=0, o_idle=1, no done/err, rr pointer 0. A subsequent req1 is granted.
6. Operand stability: change i_in1 of the owner after grant -> o_simd_in1 keeps the latched value until S_DONE.

Source files
------------

// File: rtl/ren_simd_arb_pkg.sv
// Shared definitions for the setup-stage SIMD arbiter and its helpers.
//   state_e    : sequencer states (S_IDLE / S_ISSUE / S_DONE)
//   OP_*       : FP_SIMD opcodes
//   LANE_W/N   : default FP word width and SIMD lane count
package ren_simd_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;

  // 22-bit FP word: sign, 5-bit exponent, 16-bit fraction
  localparam int LANE_W = 22;
  localparam int LANE_N = 4;

endpackage

// File: rtl/ren_simd_arb_rr_pick.sv
// ren_rr_pick: combinational round-robin priority picker.
//   req : request vector
//   ptr : index with highest priority this round
//   gnt : one-hot winner (zero when no request)
//   idx : binary index of the winner (zero when no request)
module ren_rr_pick #(
  parameter int N_REQ = 2,
  parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PW-1:0]    idx
);

  logic found;

  // Two passes: first ptr..N_REQ-1, then wrap to 0..ptr-1.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && req[j] && (j >= int'(ptr))) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = PW'(j);
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && req[j] && (j < int'(ptr))) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/ren_simd_arb.sv
// ren_simd_arb: round-robin arbiter/sequencer sharing one LANES-wide FP_SIMD
// unit between N_REQ setup-stage requesters.
//   clk, rstn          : clock, synchronous reset (active HIGH)
//   i_req/i_in1/i_in2/i_opcode : per-requester request level and operands
//   o_grant / o_done / o_err   : one-hot grant pulse, one-hot done pulse, abort flag
//   o_result, o_idle           : captured SIMD result, idle indicator
//   o_simd_*, i_simd_*         : interface to the shared SIMD unit
module ren_simd_arb
  import ren_simd_arb_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int DW      = 22,
  parameter int LANES   = 4,
  parameter int OPW     = 3,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [N_REQ-1:0]          i_req,
  input  logic [N_REQ*LANES*DW-1:0] i_in1,
  input  logic [N_REQ*LANES*DW-1:0] i_in2,
  input  logic [N_REQ*OPW-1:0]      i_opcode,
  output logic [N_REQ-1:0]          o_grant,
  output logic [N_REQ-1:0]          o_done,
  output logic                      o_err,
  output logic [LANES*DW-1:0]       o_result,
  output logic                      o_idle,
  output logic                      o_simd_en,
  output logic [LANES*DW-1:0]       o_simd_in1,
  output logic [LANES*DW-1:0]       o_simd_in2,
  output logic [OPW-1:0]            o_simd_opcode,
  input  logic [LANES*DW-1:0]       i_simd_out,
  input  logic                      i_simd_valid,
  input  logic                      i_simd_busy
);

  localparam int VW  = LANES * DW;
  localparam int PW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WDW = $clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [PW-1:0]    rr_q, rr_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [WDW-1:0]   wd_q, wd_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             err_q, err_d;
  logic [VW-1:0]    result_q, result_d;
  logic             idle_q, idle_d;
  logic             en_q, en_d;
  logic [VW-1:0]    in1_q, in1_d, in2_q, in2_d;
  logic [OPW-1:0]   opc_q, opc_d;

  logic [N_REQ-1:0] pick_gnt;
  logic [PW-1:0]    pick_idx;
  logic [VW-1:0]    in1_sel, in2_sel;
  logic [OPW-1:0]   opc_sel;

  ren_rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
    .req (i_req),
    .ptr (rr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // Operand mux for the current winner
  always_comb begin
    in1_sel = '0;
    in2_sel = '0;
    opc_sel = '0;
    for (int r = 0; r < N_REQ; r++) begin
      if (pick_idx == PW'(r)) begin
        in1_sel = i_in1[r*VW +: VW];
        in2_sel = i_in2[r*VW +: VW];
        opc_sel = i_opcode[r*OPW +: OPW];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    owner_d  = owner_q;
    wd_d     = wd_q;
    grant_d  = '0;
    done_d   = '0;
    err_d    = 1'b0;
    result_d = result_q;
    idle_d   = idle_q;
    en_d     = en_q;
    in1_d    = in1_q;
    in2_d    = in2_q;
    opc_d    = opc_q;
    case (state_q)
      S_IDLE: begin
        if (|i_req && !i_simd_busy) begin
          state_d = S_ISSUE;
          owner_d = pick_idx;
          wd_d    = '0;
          in1_d   = in1_sel;
          in2_d   = in2_sel;
          opc_d   = opc_sel;
          grant_d = pick_gnt;
          en_d    = 1'b1;
          idle_d  = 1'b0;
        end
      end
      S_ISSUE: begin
        // Valid is tested first so a result arriving on the timeout cycle wins.
        if (i_simd_valid) begin
          result_d        = i_simd_out;
          state_d         = S_DONE;
          en_d            = 1'b0;
          done_d[owner_q] = 1'b1;
        end else if (wd_q == WDW'(TIMEOUT)) begin
          result_d        = '0;
          err_d           = 1'b1;
          state_d         = S_DONE;
          en_d            = 1'b0;
          done_d[owner_q] = 1'b1;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      S_DONE: begin
        rr_d    = (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + PW'(1);
        state_d = S_IDLE;
        idle_d  = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        idle_d  = 1'b1;
        en_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q  <= S_IDLE;
      rr_q     <= '0;
      owner_q  <= '0;
      wd_q     <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
      idle_q   <= 1'b1;
      en_q     <= 1'b0;
      in1_q    <= '0;
      in2_q    <= '0;
      opc_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      owner_q  <= owner_d;
      wd_q     <= wd_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
      idle_q   <= idle_d;
      en_q     <= en_d;
      in1_q    <= in1_d;
      in2_q    <= in2_d;
      opc_q    <= opc_d;
    end
  end

  assign o_grant       = grant_q;
  assign o_done        = done_q;
  assign o_err         = err_q;
  assign o_result      = result_q;
  assign o_idle        = idle_q;
  assign o_simd_en     = en_q;
  assign o_simd_in1    = in1_q;
  assign o_simd_in2    = in2_q;
  assign o_simd_opcode = opc_q;

endmodule

// File: tb/tb_ren_simd_arb.sv
// Directed bench for ren_simd_arb with a latency-programmable SIMD model and
// a done-pulse scoreboard (expected owner/result/err queued at request time).
module tb_ren_simd_arb;

  localparam int N_REQ   = 2;
  localparam int DW      = 22;
  localparam int LANES   = 4;
  localparam int OPW     = 3;
  localparam int TIMEOUT = 4;
  localparam int VW      = LANES * DW;

  logic                      clk;
  logic                      rstn;
  logic [N_REQ-1:0]          i_req;
  logic [N_REQ*VW-1:0]       i_in1, i_in2;
  logic [N_REQ*OPW-1:0]      i_opcode;
  logic [N_REQ-1:0]          o_grant, o_done;
  logic                      o_err, o_idle, o_simd_en;
  logic [VW-1:0]             o_result, o_simd_in1, o_simd_in2;
  logic [OPW-1:0]            o_simd_opcode;
  logic [VW-1:0]             i_simd_out;
  logic                      i_simd_valid, i_simd_busy;

  ren_simd_arb #(.N_REQ(N_REQ), .DW(DW), .LANES(LANES), .OPW(OPW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn), .i_req(i_req), .i_in1(i_in1), .i_in2(i_in2),
    .i_opcode(i_opcode), .o_grant(o_grant), .o_done(o_done), .o_err(o_err),
    .o_result(o_result), .o_idle(o_idle), .o_simd_en(o_simd_en),
    .o_simd_in1(o_simd_in1), .o_simd_in2(o_simd_in2), .o_simd_opcode(o_simd_opcode),
    .i_simd_out(i_simd_out), .i_simd_valid(i_simd_valid), .i_simd_busy(i_simd_busy)
  );

  typedef struct {
    int            idx;
    logic [VW-1:0] res;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   sim_lat  = -1;   // ISSUE cycles before valid; -1 = never valid
  int   issue_cnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int idx, input logic [VW-1:0] res, input logic err);
    exp_t e;
    e.idx = idx; e.res = res; e.err = err;
    exp_q.push_back(e);
  endtask

  // SIMD model: result = in1 ^ in2, valid after sim_lat ISSUE cycles
  initial begin
    i_simd_valid = 1'b0;
    i_simd_out   = '0;
    forever begin
      @(negedge clk);
      if (o_simd_en) begin
        i_simd_valid = (sim_lat >= 0) && (issue_cnt == sim_lat);
        i_simd_out   = o_simd_in1 ^ o_simd_in2;
        issue_cnt++;
      end else begin
        i_simd_valid = 1'b0;
        issue_cnt    = 0;
      end
    end
  end

  // Scoreboard: every done pulse must match the oldest queued expectation
  initial begin
    exp_t e;
    logic [N_REQ-1:0] oh;
    forever begin
      @(negedge clk);
      if (|o_done) begin
        if (exp_q.size() == 0) chk("done_unexpected", o_done, '0);
        else begin
          e = exp_q.pop_front();
          oh = '0; oh[e.idx] = 1'b1;
          chk("done_owner", o_done, oh);
          chk("done_result", o_result, e.res);
          chk("done_err", o_err, e.err);
        end
      end else if (o_err) chk("err_without_done", o_err, 1'b0);
    end
  end

  // Runs until a done pulse; reports grant/done cycle (1 = first negedge) and en count
  task automatic run_op(input logic drop, output int g_cyc, output int d_cyc,
                        output int en_cnt, output logic [N_REQ-1:0] g_vec);
    int c;
    c = 0; g_cyc = -1; d_cyc = -1; en_cnt = 0; g_vec = '0;
    while (d_cyc < 0 && c < 200) begin
      @(negedge clk);
      c++;
      if (|o_grant) begin
        g_cyc = c; g_vec = o_grant;
        if (drop) i_req = i_req & ~o_grant;
      end
      if (o_simd_en) en_cnt++;
      if (|o_done) d_cyc = c;
    end
    chk("op_bound", d_cyc > 0, 1'b1);
  endtask

  task automatic do_reset();
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b0;
  endtask

  initial begin
    int g, d, en;
    logic [N_REQ-1:0] gv;
    logic [VW-1:0] b0, b1;
    b0 = VW'(88'h10); b1 = VW'(88'h20);
    rstn = 1'b1; i_req = '0; i_in1 = '0; i_in2 = '0; i_opcode = '0; i_simd_busy = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_idle", o_idle, 1'b1);
    chk("rst_en", o_simd_en, 1'b0);
    chk("rst_pulses", {o_grant, o_done, o_err}, '0);
    chk("rst_result", o_result, '0);
    chk("rst_operands", {o_simd_in1, o_simd_in2, o_simd_opcode}, '0);
    rstn = 1'b0;

    // 1: single op, L=3
    i_in1[0 +: VW] = VW'(88'h0ABC); i_in2[0 +: VW] = '0; i_opcode[0 +: OPW] = 3'd2;
    sim_lat = 3; push(0, VW'(88'h0ABC), 1'b0); i_req = 2'b01;
    run_op(1'b1, g, d, en, gv);
    chk("t1_grant_cyc", g, 1); chk("t1_grant_vec", gv, 2'b01);
    chk("t1_en_cycles", en, 4); chk("t1_done_cyc", d, 5);
    chk("t1_opcode", o_simd_opcode, 3'd2);
    @(negedge clk);
    chk("t1_idle_after", o_idle, 1'b1);
    chk("t1_result_hold", o_result, VW'(88'h0ABC));

    // 2: contention from reset, L=0, alternation and L+3 throughput
    do_reset();
    i_in1 = {VW'(88'h222), VW'(88'h111)}; i_in2 = {b1, b0};
    sim_lat = 0;
    push(0, VW'(88'h111) ^ b0, 1'b0); push(1, VW'(88'h222) ^ b1, 1'b0);
    push(0, VW'(88'h111) ^ b0, 1'b0); push(1, VW'(88'h222) ^ b1, 1'b0);
    i_req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      run_op(1'b0, g, d, en, gv);
      chk("t2_order", gv, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("t2_grant_cyc", g, (k == 0) ? 1 : 2);
      chk("t2_done_cyc", d, g + 1);
    end
    i_req = '0;

    // 3: busy gating
    @(negedge clk);
    i_simd_busy = 1'b1; i_in1[VW +: VW] = VW'(88'h333); sim_lat = 1;
    push(1, VW'(88'h333) ^ b1, 1'b0); i_req = 2'b10;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t3_busy_hold", {o_grant, o_simd_en}, '0);
    end
    i_simd_busy = 1'b0;
    run_op(1'b1, g, d, en, gv);
    chk("t3_grant_cyc", g, 1); chk("t3_grant_vec", gv, 2'b10);
    chk("t3_en_cycles", en, 2); chk("t3_done_cyc", d, 3);

    // 4: watchdog abort, then normal op, then valid exactly at timeout
    @(negedge clk);
    i_in1[0 +: VW] = VW'(88'h444); sim_lat = -1; push(0, '0, 1'b1); i_req = 2'b01;
    run_op(1'b1, g, d, en, gv);
    chk("t4_wd_grant", g, 1); chk("t4_wd_en", en, 5); chk("t4_wd_done", d, 6);
    @(negedge clk);
    i_in1[VW +: VW] = VW'(88'h555); sim_lat = 2; push(1, VW'(88'h555) ^ b1, 1'b0); i_req = 2'b10;
    run_op(1'b1, g, d, en, gv);
    chk("t4_next_en", en, 3); chk("t4_next_done", d, 4);
    @(negedge clk);
    i_in1[0 +: VW] = VW'(88'h666); sim_lat = 4; push(0, VW'(88'h666) ^ b0, 1'b0); i_req = 2'b01;
    run_op(1'b1, g, d, en, gv);
    chk("t4_edge_en", en, 5); chk("t4_edge_done", d, 6);

    // 5: reset in ISSUE cycle 2 (pointer was 1 before reset)
    @(negedge clk);
    sim_lat = -1; i_req = 2'b01;
    @(negedge clk);
    chk("t5_grant", o_grant, 2'b01);
    i_req = '0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("t5_en_drop", o_simd_en, 1'b0);
    chk("t5_idle", o_idle, 1'b1);
    chk("t5_no_pulse", {o_done, o_err, o_grant}, '0);
    rstn = 1'b0;
    i_in1 = {VW'(88'h888), VW'(88'h777)}; sim_lat = 1;
    push(0, VW'(88'h777) ^ b0, 1'b0); i_req = 2'b11;
    run_op(1'b1, g, d, en, gv);
    i_req = '0;
    chk("t5_ptr_reset", gv, 2'b01); chk("t5_grant_cyc", g, 1);

    // 6: operand stability after grant
    @(negedge clk);
    i_in1[VW +: VW] = VW'(88'h999); i_opcode[OPW +: OPW] = 3'd1; sim_lat = 3;
    push(1, VW'(88'h999) ^ b1, 1'b0); i_req = 2'b10;
    @(negedge clk);
    chk("t6_grant", o_grant, 2'b10);
    i_req = '0; i_in1[VW +: VW] = VW'(88'hDEAD); i_opcode[OPW +: OPW] = 3'd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6_in1_stable", o_simd_in1, VW'(88'h999));
      chk("t6_opc_stable", o_simd_opcode, 3'd1);
      chk("t6_en", o_simd_en, 1'b1);
    end
    @(negedge clk);
    chk("t6_done", o_done, 2'b10);
    chk("t6_in1_at_done", o_simd_in1, VW'(88'h999));

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
